// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with integrated storage, registered full/empty/threshold
// flags, fill level and sticky overflow/underflow capture.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int AF_LEVEL     = 14,
  parameter int AE_LEVEL     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic                    r_en,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic                    r_valid,
  output logic                    w_full,
  output logic                    r_empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADDRESS_SIZE:0]   level,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int DEPTH = 1 << ADDRESS_SIZE;
  localparam int PTR_W = ADDRESS_SIZE + 1;
  localparam logic [PTR_W-1:0] AF_THR = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] w_ptr, r_ptr;
  logic [PTR_W-1:0] w_ptr_next, r_ptr_next, next_level;
  logic             wr_ok, rd_ok;
  logic             next_full, next_empty;

  // Accept decisions use only the registered flags, never the next-state ones.
  assign wr_ok = w_en & ~w_full;
  assign rd_ok = r_en & ~r_empty;

  always_comb begin
    w_ptr_next = w_ptr + PTR_W'(wr_ok);
    r_ptr_next = r_ptr + PTR_W'(rd_ok);
    next_level = w_ptr_next - r_ptr_next;
    next_full  = (w_ptr_next[ADDRESS_SIZE] != r_ptr_next[ADDRESS_SIZE]) &&
                 (w_ptr_next[ADDRESS_SIZE-1:0] == r_ptr_next[ADDRESS_SIZE-1:0]);
    next_empty = (w_ptr_next == r_ptr_next);
  end

  // NOTE: storage has no reset; a reset only moves the pointers, so stale
  // words are unreachable and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[w_ptr[ADDRESS_SIZE-1:0]] <= w_data;
    end
  end

  // NOTE: all state below uses non-blocking assignment so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      level        <= '0;
      w_full       <= 1'b0;
      r_empty      <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      r_valid      <= 1'b0;
      r_data       <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      w_ptr        <= w_ptr_next;
      r_ptr        <= r_ptr_next;
      level        <= next_level;
      w_full       <= next_full;
      r_empty      <= next_empty;
      almost_full  <= (next_level >= AF_THR);
      almost_empty <= (next_level <= AE_THR);
      r_valid      <= rd_ok;
      if (rd_ok) begin
        r_data <= mem[r_ptr[ADDRESS_SIZE-1:0]];
      end
      // A fresh error event outranks a simultaneous clear.
      overflow  <= (overflow  & ~clr_err) | (w_en & w_full);
      underflow <= (underflow & ~clr_err) | (r_en & r_empty);
    end
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO with integrated storage: write/read pointer control, registered full/empty flags, programmable almost-full/almost-empty thresholds, fill-level output and sticky overflow/underflow error flags. It is the single-clock-domain successor of the write-side pointer/full logic of the async FIFO. It is generalised in data width and depth and adds level reporting, thresholds and error capture. It sits between a producer and a consumer on the same clock, for rate buffering inside a clock domain.

Parameters:
DATA_WIDTH, 8, width of w_data/r_data in bits.
ADDRESS_SIZE, 4, address bits; depth = 2**ADDRESS_SIZE entries (legal 2..12).
AF_LEVEL, 14, almost_full asserts when level >= AF_LEVEL (legal 1..depth).
AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL (legal 0..depth-1).

Ports:
clk  input  1  single clock, all logic on rising edge.
rst  input  1  synchronous reset, active-high.
w_en  input  1  write request.
w_data  input  DATA_WIDTH  write data, sampled when write accepted.
r_en  input  1  read request.
r_data  output  DATA_WIDTH  read data, registered.
r_valid  output  1  one-cycle pulse, r_data holds a newly read word.
w_full  output  1  FIFO holds depth entries, registered.
r_empty  output  1  FIFO holds 0 entries, registered.
almost_full  output  1  level >= AF_LEVEL, registered.
almost_empty  output  1  level <= AE_LEVEL, registered.
level  output  ADDRESS_SIZE+1  current entry count 0..depth, registered.
overflow  output  1  sticky: write requested while w_full.
underflow  output  1  sticky: read requested while r_empty.
clr_err  input  1  clears overflow/underflow.

Behaviour:
- Reset is synchronous: rst sampled high at a clock edge sets the following values.
  - Pointers and level = 0, r_empty=1, w_full=0, almost_empty=1.
  - almost_full=0, r_valid=0, r_data=0, overflow=0, underflow=0.
  - Storage array is not reset. Reset mid-operation discards all contents; rst has priority over every other input.
- Pointers: binary, ADDRESS_SIZE+1 bits. The low ADDRESS_SIZE bits address memory. The MSB is the wrap bit; pointers wrap modulo 2**(ADDRESS_SIZE+1).
- Write accept: wr_ok = w_en & !w_full, using the registered flag. On wr_ok, mem[w_ptr low bits] <= w_data and w_ptr increments.
- Read accept: rd_ok = r_en & !r_empty, using the registered flag. On rd_ok, r_data <= mem[r_ptr low bits] and r_ptr increments.
  - r_valid = 1 in the cycle after rd_ok, else 0. Read latency is 1 cycle.
  - r_data holds its last value when there is no read.
- Flags are computed from the next-state pointers and registered, so they reflect an accepted access in the cycle after it.
  - next_level = w_ptr_next - r_ptr_next, modulo, ADDRESS_SIZE+1 bits.
  - w_full <= next pointers have differing MSBs and equal low bits.
  - r_empty <= next pointers are equal.
  - almost_full <= next_level >= AF_LEVEL.
  - almost_empty <= next_level <= AE_LEVEL.
  - level <= next_level.
- Simultaneous write and read:
  - Non-empty and non-full: both accepted; level unchanged; flags unchanged.
  - When full: read accepted, write rejected; overflow sets; level becomes depth-1.
  - When empty: write accepted, read rejected; underflow sets; level becomes 1; no r_valid.
- Errors:
  - overflow sets on (w_en & w_full); underflow sets on (r_en & r_empty).
  - A rejected access never modifies pointers or memory.
  - clr_err clears both flags. If clr_err coincides with a new error event, the flag is set (set wins).
- The memory read address never equals the write address in a cycle where the same location is both written and read. This is guaranteed by the full/empty rules; no bypass path exists.

Test Plan:
- Reset then idle 3 cycles -> r_empty=1, almost_empty=1, w_full=0, almost_full=0, level=0, r_valid=0, overflow=0, underflow=0.
- Defaults: 16 writes of 0x00..0x0F -> level reaches 16.
  - almost_full rises the cycle after the 14th write.
  - w_full rises the cycle after the 16th write.
  - A 17th write sets overflow, and level stays 16.
- From full: 16 reads -> r_data = 0x00..0x0F in order, each one cycle after its read with r_valid=1.
  - almost_empty rises after the 14th read; r_empty rises after the 16th read.
  - A 17th read sets underflow and gives no r_valid.
- Half full (level=8): 20 cycles of simultaneous w_en/r_en -> level stays 8, data returns in FIFO order, flags unchanged, pointers wrap past 31->0 correctly.
- Full, w_en and r_en together -> read data correct, overflow=1, level=15. Empty, w_en and r_en together -> underflow=1, level=1, r_valid=0.
- Error clearing and mid-operation reset:
  - clr_err together with a new overflow event -> overflow stays 1.
  - clr_err alone on the next cycle -> overflow=0.
  - rst asserted at level=9 -> next cycle level=0, r_empty=1, all flags at reset values.
